// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth back end: sums WIDTH/2 signed partial products, each weighted
// by 4^i, into a 2*WIDTH-bit product presented on a valid/ready port.
module booth_pp_accumulator #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pp_valid,
  output logic               pp_ready,
  input  logic [WIDTH:0]     pp_data,
  input  logic               pp_last,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] prod_data,
  output logic               seq_err
);

  localparam int NUM_PP = WIDTH / 2;
  localparam int CW     = (NUM_PP > 2) ? $clog2(NUM_PP) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_prod_data;
  logic                r_prod_valid;
  logic                r_seq_err;

  logic [2*WIDTH-1:0]  w_pp_ext;
  logic [2*WIDTH-1:0]  w_pp_weighted;
  logic [2*WIDTH-1:0]  w_sum;
  logic                w_last_digit;

  // Digit i carries weight 4^i, i.e. a left shift by 2*count.
  assign w_pp_ext      = {{(WIDTH-1){pp_data[WIDTH]}}, pp_data};
  assign w_pp_weighted = w_pp_ext << {r_count, 1'b0};
  assign w_sum         = r_acc + w_pp_weighted;
  assign w_last_digit  = (r_count == CW'(NUM_PP - 1));

  assign pp_ready   = (r_state == ACCUM);
  assign prod_valid = r_prod_valid;
  assign prod_data  = r_prod_data;
  assign seq_err    = r_seq_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_count      <= '0;
      r_acc        <= '0;
      r_prod_data  <= '0;
      r_prod_valid <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (pp_valid) begin
            r_acc <= w_sum;
            // Framing is by count; pp_last only flags a disagreement.
            if (pp_last != w_last_digit) begin
              r_seq_err <= 1'b1;
            end
            if (w_last_digit) begin
              r_prod_data  <= w_sum;
              r_prod_valid <= 1'b1;
              r_count      <= '0;
              r_state      <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          if (prod_ready) begin
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
            r_state      <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
Sequential back end of the radix-4 Booth multiplier. It accepts the WIDTH/2 signed partial products from the Booth encoder stage over a valid/ready stream, one per digit, lowest digit first. Each partial product is weighted by 4^i and summed into a 2*WIDTH-bit product, which is then presented on a valid/ready output port. It closes the multiplier datapath between the encoder array and the product register/consumer.

Parameters:
WIDTH, 16, multiplicand/multiplier width; must be even, >= 4
NUM_PP, WIDTH/2, partial products per product (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
pp_valid  input  1  partial product valid
pp_ready  output  1  accumulator can accept a partial product
pp_data  input  WIDTH+1  partial product, signed two's complement
pp_last  input  1  upstream marks final partial product of a set
prod_valid  output  1  product valid
prod_ready  input  1  consumer accepts product
prod_data  output  2*WIDTH  signed product
seq_err  output  1  sticky framing error flag

Behaviour:
- Reset: async on rst high. State=ACCUM, count=0, acc=0, prod_valid=0, prod_data=0, seq_err=0, pp_ready=1 after reset deasserts (combinational from state).
- States: ACCUM, DONE.
- ACCUM: pp_ready=1, prod_valid=0. Accept on pp_valid&&pp_ready at a rising edge.
  - acc <= acc + (sext(pp_data to 2*WIDTH) << 2*count), modulo 2^(2*WIDTH).
  - count < NUM_PP-1: count++, stay ACCUM.
  - count == NUM_PP-1: prod_data <= final sum, prod_valid <= 1, count <= 0, go DONE.
- Latency: prod_valid rises the cycle after the final partial product is accepted. No extra pipeline stage.
- DONE: pp_ready=0, prod_valid=1, prod_data held stable until handshake. On prod_valid&&prod_ready: prod_valid <= 0, acc <= 0, go ACCUM. The next pp can be accepted the cycle after. No pp is taken in the handshake cycle.
- Framing is by count only; pp_last does not end a set early or extend it.
- seq_err is set on an accepted pp when:
  - pp_last=1 and count != NUM_PP-1, or
  - pp_last=0 and count == NUM_PP-1.
  It stays set until reset. Accumulation continues unaffected.
- pp_valid while pp_ready=0 is ignored. Upstream must hold pp_data until accepted.
- pp_data holds one signed (WIDTH+1)-bit value. The encoder's -2A for A = -2^(WIDTH-1) is not representable, so a product of -2^(WIDTH-1) * -2^(WIDTH-1) is out of range and is upstream's responsibility. The block adds whatever it receives.
- Reset mid-set or in DONE: all state cleared immediately. The partial set is discarded and no product is emitted.
- prod_data keeps its last value after handshake; only prod_valid qualifies it.

Test Plan:
- Positive product, A=3, B=5: send pp = 17'h00003, 17'h00003, then six 17'h00000, pp_last on the 8th -> one cycle later prod_valid=1, prod_data=32'h0000000F, seq_err=0.
- Negative product, A=-1, B=2: send pp0 = 17'h00002, pp1 = 17'h1FFFF, pp2..7 = 0 -> prod_data=32'hFFFFFFFE.
- Backpressure: hold prod_ready=0 for 5 cycles after prod_valid -> prod_data stable, pp_ready=0, extra pp_valid ignored. Then prod_ready=1 for 1 cycle -> prod_valid=0 next cycle, pp_ready=1. A second set with pp0=17'h00001, rest 0 -> 32'h00000001 (acc was cleared).
- Gapped input, A=3, B=5 set with pp_valid low on alternate cycles -> same 32'h0000000F. Product appears exactly one cycle after the 8th accept.
- Framing error: pp_last=1 on the 3rd pp of a set -> seq_err=1 from the next cycle. Product is still emitted after 8 accepts, and seq_err stays 1 across subsequent correct sets until rst.
- Reset mid-operation: accept 4 pps of 17'h00001, pulse rst asynchronously (between edges) -> prod_valid=0, seq_err=0 immediately. A fresh set of pp0=17'h00005, rest 0 -> 32'h00000005.
